// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared program-counter width, reset address and address type
// Used by pc, pc_next and the neighbouring stack/fetch blocks.
package pc_pkg;

  localparam int PC_WIDTH = 8;
  localparam logic [PC_WIDTH-1:0] PC_RESET_ADDR = 8'h00;

  typedef logic [PC_WIDTH-1:0] pc_addr_t;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-address mux and return-address adder
// Ports:
//   pc        current program counter
//   jump      jump request
//   target    jump target address
//   next_addr value the register loads at the next edge
//   ret_addr  pc + 1, wrapping modulo 2^WIDTH
module pc_next
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             jump,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] next_addr,
  output logic [WIDTH-1:0] ret_addr
);

  // Single adder serves both the increment path and the return address;
  // the carry-out is dropped so FF wraps to 00.
  logic [WIDTH-1:0] incr;

  always_comb begin
    incr      = pc + WIDTH'(1);
    ret_addr  = incr;
    next_addr = jump ? target : incr;
  end

endmodule

// File: rtl/pc.sv
// rtl/pc.sv - program counter register with async reset and jump load
// Ports:
//   i_Timming          clock, rising edge
//   i_Rst              asynchronous active-high reset
//   i_Senal_de_salto   jump request
//   i_Direccion_salto  jump target
//   o_Fetch            current instruction-fetch address (registered)
//   o_Stack            return address, o_Fetch + 1 (combinational from pc only)
module pc
  import pc_pkg::*;
#(
  parameter int               WIDTH      = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_ADDR = PC_RESET_ADDR
) (
  input  logic             i_Timming,
  input  logic             i_Rst,
  input  logic             i_Senal_de_salto,
  input  logic [WIDTH-1:0] i_Direccion_salto,
  output logic [WIDTH-1:0] o_Fetch,
  output logic [WIDTH-1:0] o_Stack
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] next_addr;
  logic [WIDTH-1:0] ret_addr;

  pc_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .pc        (pc_q),
    .jump      (i_Senal_de_salto),
    .target    (i_Direccion_salto),
    .next_addr (next_addr),
    .ret_addr  (ret_addr)
  );

  always_ff @(posedge i_Timming or posedge i_Rst) begin
    if (i_Rst) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= next_addr;
    end
  end

  assign o_Fetch = pc_q;
  assign o_Stack = ret_addr;

endmodule

// File: tb/tb_pc.sv
// tb/tb_pc.sv - directed self-checking bench for pc
module tb_pc;

  logic       clk;
  logic       rst;
  logic       jump;
  logic [7:0] target;
  logic [7:0] fetch;
  logic [7:0] stack;

  int pass_cnt;
  int total_cnt;

  pc #(
    .WIDTH      (8),
    .RESET_ADDR (8'h00)
  ) dut (
    .i_Timming         (clk),
    .i_Rst             (rst),
    .i_Senal_de_salto  (jump),
    .i_Direccion_salto (target),
    .o_Fetch           (fetch),
    .o_Stack           (stack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++;
      if (fetch !== 8'h00) $display("FAIL reset_fetch[%0d]: got %h expected 00", i, fetch);
      else pass_cnt++;
      total_cnt++;
      if (stack !== 8'h01) $display("FAIL reset_stack[%0d]: got %h expected 01", i, stack);
      else pass_cnt++;
    end
    rst = 1'b0;
  endtask

  task automatic test_count();
    logic [7:0] exp_f [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] exp_s [4] = '{8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if (fetch !== exp_f[i]) $display("FAIL count_fetch[%0d]: got %h expected %h", i, fetch, exp_f[i]);
      else pass_cnt++;
      total_cnt++;
      if (stack !== exp_s[i]) $display("FAIL count_stack[%0d]: got %h expected %h", i, stack, exp_s[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_jump();
    logic       j_in  [3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] exp_f [3] = '{8'h1F, 8'h20, 8'h21};
    logic [7:0] exp_s [3] = '{8'h20, 8'h21, 8'h22};
    target = 8'h1F;
    for (int i = 0; i < 3; i++) begin
      jump = j_in[i];
      step();
      total_cnt++;
      if (fetch !== exp_f[i]) $display("FAIL jump_fetch[%0d]: got %h expected %h", i, fetch, exp_f[i]);
      else pass_cnt++;
      total_cnt++;
      if (stack !== exp_s[i]) $display("FAIL jump_stack[%0d]: got %h expected %h", i, stack, exp_s[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    // Pulse reset well between edges: fetch must clear with no edge.
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if (fetch !== 8'h00) $display("FAIL async_rst_fetch: got %h expected 00", fetch);
    else pass_cnt++;
    total_cnt++;
    if (stack !== 8'h01) $display("FAIL async_rst_stack: got %h expected 01", stack);
    else pass_cnt++;
    #1 rst = 1'b0;
    step();
    total_cnt++;
    if (fetch !== 8'h01) $display("FAIL async_rst_release: got %h expected 01", fetch);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic       j_in  [3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] exp_f [3] = '{8'hFE, 8'hFF, 8'h00};
    logic [7:0] exp_s [3] = '{8'hFF, 8'h00, 8'h01};
    target = 8'hFE;
    for (int i = 0; i < 3; i++) begin
      jump = j_in[i];
      step();
      total_cnt++;
      if (fetch !== exp_f[i]) $display("FAIL wrap_fetch[%0d]: got %h expected %h", i, fetch, exp_f[i]);
      else pass_cnt++;
      total_cnt++;
      if (stack !== exp_s[i]) $display("FAIL wrap_stack[%0d]: got %h expected %h", i, stack, exp_s[i]);
      else pass_cnt++;
    end
    // Return address must not follow the jump inputs.
    target = 8'hA5;
    jump   = 1'b1;
    #1;
    total_cnt++;
    if (stack !== 8'h01) $display("FAIL stack_indep: got %h expected 01", stack);
    else pass_cnt++;
    jump = 1'b0;
  endtask

  task automatic test_self_jump();
    target = 8'h10;
    jump   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (fetch !== 8'h10) $display("FAIL self_jump_fetch[%0d]: got %h expected 10", i, fetch);
      else pass_cnt++;
      total_cnt++;
      if (stack !== 8'h11) $display("FAIL self_jump_stack[%0d]: got %h expected 11", i, stack);
      else pass_cnt++;
    end
    // Reset beats a pending jump, and edges during reset are ignored.
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if (fetch !== 8'h00) $display("FAIL rst_over_jump: got %h expected 00", fetch);
    else pass_cnt++;
    step();
    total_cnt++;
    if (fetch !== 8'h00) $display("FAIL rst_hold_edge: got %h expected 00", fetch);
    else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++;
    if (fetch !== 8'h10) $display("FAIL jump_after_rst: got %h expected 10", fetch);
    else pass_cnt++;
    jump = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst    = 1'b1;
    jump   = 1'b0;
    target = 8'h00;
    test_reset();
    test_count();
    test_jump();
    test_async_reset();
    test_wrap();
    test_self_jump();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
